// File: rtl/mdio_phy_emu.sv
// Clause-22 MDIO responder emulating a PHY register set whose link/speed/duplex
// mirror MCU-reported status; MDC/MDIO are oversampled in the clk domain.
module mdio_phy_emu #(
   parameter logic [4:0]  PHY_ADDR     = 5'd1,
   parameter logic [15:0] PHY_ID1      = 16'h0141,
   parameter logic [15:0] PHY_ID2      = 16'h0CC2,
   parameter int          PREAMBLE_MIN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        link,
   input  logic [1:0]  speed,
   input  logic        duplex,
   output logic [15:0] bmcr,
   output logic        wr_stb,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data
);

   localparam logic [5:0]  PRE_MIN  = 6'(PREAMBLE_MIN);
   localparam logic [15:0] BMCR_RST = 16'h1140;
   localparam logic [15:0] ANAR_RST = 16'h01E1;

   typedef enum logic [2:0] {
      IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA
   } state_t;

   state_t      state, state_nx;
   logic [2:0]  mdc_sync;
   logic [1:0]  mdio_sync;
   logic        mdc_rise, bit_in;
   logic [4:0]  bit_cnt, bit_cnt_nx;
   logic [5:0]  ones_cnt, ones_cnt_nx;
   logic        op_hi, op_hi_nx;
   logic        is_read, is_read_nx;
   logic [4:0]  phy_sh, phy_sh_nx;
   logic [4:0]  reg_sh, reg_sh_nx;
   logic [15:0] shreg, shreg_nx;
   logic        mdio_o_nx, mdio_oe_nx;
   logic [15:0] bmcr_nx, anar, anar_nx;
   logic        wr_stb_nx;
   logic [4:0]  wr_addr_nx;
   logic [15:0] wr_data_nx;
   logic [15:0] read_val, wdata_full;

   // Synchronizers: stage 3 of mdc exists only to find its rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdc_sync  <= '0;
         mdio_sync <= '0;
      end else begin
         mdc_sync  <= {mdc_sync[1:0], mdc};
         mdio_sync <= {mdio_sync[0], mdio_i};
      end
   end

   assign mdc_rise   = mdc_sync[1] & ~mdc_sync[2];
   assign bit_in     = mdio_sync[1];
   assign wdata_full = {shreg[14:0], bit_in};

   always_comb begin
      read_val = '0;
      case (reg_sh)
         5'd0:    read_val = bmcr;
         5'd1:    read_val = 16'h7949 | {10'b0, link, 2'b00, link, 2'b00};
         5'd2:    read_val = PHY_ID1;
         5'd3:    read_val = PHY_ID2;
         5'd4:    read_val = anar;
         5'd5:    read_val = link ? 16'hC1E1 : 16'h0000;
         5'd17:   read_val = {speed, duplex, 1'b0, link, link, 10'b0};
         default: read_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         ones_cnt <= '0;
         op_hi    <= 1'b0;
         is_read  <= 1'b0;
         phy_sh   <= '0;
         reg_sh   <= '0;
         shreg    <= '0;
         mdio_o   <= 1'b0;
         mdio_oe  <= 1'b0;
         bmcr     <= BMCR_RST;
         anar     <= ANAR_RST;
         wr_stb   <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state    <= state_nx;
         bit_cnt  <= bit_cnt_nx;
         ones_cnt <= ones_cnt_nx;
         op_hi    <= op_hi_nx;
         is_read  <= is_read_nx;
         phy_sh   <= phy_sh_nx;
         reg_sh   <= reg_sh_nx;
         shreg    <= shreg_nx;
         mdio_o   <= mdio_o_nx;
         mdio_oe  <= mdio_oe_nx;
         bmcr     <= bmcr_nx;
         anar     <= anar_nx;
         wr_stb   <= wr_stb_nx;
         wr_addr  <= wr_addr_nx;
         wr_data  <= wr_data_nx;
      end
   end

   // Frame decoder: every field advances only on a detected mdc rising edge
   always_comb begin
      state_nx    = state;
      bit_cnt_nx  = bit_cnt;
      ones_cnt_nx = ones_cnt;
      op_hi_nx    = op_hi;
      is_read_nx  = is_read;
      phy_sh_nx   = phy_sh;
      reg_sh_nx   = reg_sh;
      shreg_nx    = shreg;
      mdio_o_nx   = mdio_o;
      mdio_oe_nx  = mdio_oe;
      bmcr_nx     = bmcr;
      anar_nx     = anar;
      wr_stb_nx   = 1'b0;
      wr_addr_nx  = wr_addr;
      wr_data_nx  = wr_data;

      if (mdc_rise) begin
         case (state)
            IDLE: begin
               if (bit_in) begin
                  if (ones_cnt < PRE_MIN) ones_cnt_nx = ones_cnt + 6'd1;
               end else begin
                  if (ones_cnt >= PRE_MIN) state_nx = ST;
                  ones_cnt_nx = '0;
               end
            end
            ST: begin
               bit_cnt_nx = '0;
               state_nx   = bit_in ? OP : IDLE;
            end
            OP: begin
               if (bit_cnt == 5'd0) begin
                  op_hi_nx   = bit_in;
                  bit_cnt_nx = 5'd1;
               end else begin
                  bit_cnt_nx = '0;
                  if ({op_hi, bit_in} == 2'b10) begin
                     is_read_nx = 1'b1;
                     state_nx   = PHYAD;
                  end else if ({op_hi, bit_in} == 2'b01) begin
                     is_read_nx = 1'b0;
                     state_nx   = PHYAD;
                  end else begin
                     state_nx   = IDLE;
                  end
               end
            end
            PHYAD: begin
               phy_sh_nx = {phy_sh[3:0], bit_in};
               if (bit_cnt == 5'd4) begin
                  bit_cnt_nx = '0;
                  state_nx   = REGAD;
               end else begin
                  bit_cnt_nx = bit_cnt + 5'd1;
               end
            end
            REGAD: begin
               reg_sh_nx = {reg_sh[3:0], bit_in};
               if (bit_cnt == 5'd4) begin
                  bit_cnt_nx = '0;
                  state_nx   = (phy_sh == PHY_ADDR) ? TA : IDLE;
               end else begin
                  bit_cnt_nx = bit_cnt + 5'd1;
               end
            end
            // Reads take their snapshot here so later status changes cannot tear the word
            TA: begin
               if (is_read) begin
                  shreg_nx   = read_val;
                  mdio_oe_nx = 1'b1;
                  mdio_o_nx  = 1'b0;
                  bit_cnt_nx = '0;
                  state_nx   = RDATA;
               end else if (bit_cnt == 5'd1) begin
                  bit_cnt_nx = '0;
                  state_nx   = WDATA;
               end else begin
                  bit_cnt_nx = 5'd1;
               end
            end
            RDATA: begin
               if (bit_cnt == 5'd16) begin
                  mdio_oe_nx = 1'b0;
                  mdio_o_nx  = 1'b0;
                  bit_cnt_nx = '0;
                  state_nx   = IDLE;
               end else begin
                  mdio_o_nx  = shreg[15];
                  shreg_nx   = {shreg[14:0], 1'b0};
                  bit_cnt_nx = bit_cnt + 5'd1;
               end
            end
            WDATA: begin
               shreg_nx = wdata_full;
               if (bit_cnt == 5'd15) begin
                  bit_cnt_nx = '0;
                  state_nx   = IDLE;
                  wr_stb_nx  = 1'b1;
                  wr_addr_nx = reg_sh;
                  wr_data_nx = wdata_full;
                  if (reg_sh == 5'd0) begin
                     if (wdata_full[15]) begin
                        bmcr_nx = BMCR_RST;
                        anar_nx = ANAR_RST;
                     end else begin
                        bmcr_nx = {1'b0, wdata_full[14:0]};
                     end
                  end else if (reg_sh == 5'd4) begin
                     anar_nx = wdata_full;
                  end
               end else begin
                  bit_cnt_nx = bit_cnt + 5'd1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_phy_emu.sv
// Directed bench for mdio_phy_emu: emulates an MDIO master bit by bit and
// checks reads, writes, reset behaviour and frame rejection against hand values.
module tb_mdio_phy_emu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mdc = 1'b0;
   logic        mdio_i = 1'b1;
   logic        link = 1'b0;
   logic [1:0]  speed = 2'b00;
   logic        duplex = 1'b0;
   logic        mdio_o, mdio_oe, wr_stb;
   logic [15:0] bmcr, wr_data;
   logic [4:0]  wr_addr;

   int          errors = 0;
   int          checks = 0;
   logic        oe_seen, ta_oe, ta_o, rel_oe, data_oe_all;
   int          stb_cnt;
   logic [15:0] rd_data;

   mdio_phy_emu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mdc     (mdc),
      .mdio_i  (mdio_i),
      .mdio_o  (mdio_o),
      .mdio_oe (mdio_oe),
      .link    (link),
      .speed   (speed),
      .duplex  (duplex),
      .bmcr    (bmcr),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic sampleClocks();
      repeat (5) begin
         @(negedge clk);
         if (mdio_oe === 1'b1) oe_seen = 1'b1;
         if (wr_stb === 1'b1) stb_cnt++;
      end
   endtask

   // One mdc period, 5 clk low then 5 clk high; data changes while mdc is low
   task automatic applyStimulus(input logic b);
      mdio_i = b;
      sampleClocks();
      mdc = 1'b1;
      sampleClocks();
      mdc = 1'b0;
   endtask

   task automatic runFrame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input int post);
      logic b;
      oe_seen = 1'b0; stb_cnt = 0; rd_data = '0;
      ta_oe = 1'b0; ta_o = 1'b1; rel_oe = 1'b1; data_oe_all = 1'b1;
      for (int i = 0; i < pre; i++) applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(op[1]);
      applyStimulus(op[0]);
      for (int i = 4; i >= 0; i--) applyStimulus(pa[i]);
      for (int i = 4; i >= 0; i--) applyStimulus(ra[i]);
      for (int k = 0; k < post; k++) begin
         if (op != 2'b01) b = 1'b1;
         else if (k == 0) b = 1'b1;
         else if (k == 1) b = 1'b0;
         else b = wd[17-k];
         applyStimulus(b);
         if (k == 0) begin
            ta_oe = mdio_oe;
            ta_o  = mdio_o;
         end else if (k <= 16) begin
            rd_data = {rd_data[14:0], mdio_o};
            if (mdio_oe !== 1'b1) data_oe_all = 1'b0;
         end else begin
            rel_oe = mdio_oe;
         end
      end
      mdio_i = 1'b1;
   endtask

   task automatic readCheck(input string tag, input logic [4:0] ra, input logic [15:0] expected);
      runFrame(32, 2'b10, 5'd1, ra, 16'h0000, 18);
      checkOutput({tag, " ta_oe"}, 16'(ta_oe), 16'd1);
      checkOutput({tag, " ta_o"}, 16'(ta_o), 16'd0);
      checkOutput({tag, " data"}, rd_data, expected);
      checkOutput({tag, " data_oe"}, 16'(data_oe_all), 16'd1);
      checkOutput({tag, " release_oe"}, 16'(rel_oe), 16'd0);
   endtask

   task automatic writeCheck(input string tag, input logic [4:0] ra, input logic [15:0] wd);
      runFrame(32, 2'b01, 5'd1, ra, wd, 18);
      checkOutput({tag, " stb_cnt"}, 16'(stb_cnt), 16'd1);
      checkOutput({tag, " wr_addr"}, 16'(wr_addr), 16'(ra));
      checkOutput({tag, " wr_data"}, wr_data, wd);
      checkOutput({tag, " no_drive"}, 16'(oe_seen), 16'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("rst mdio_o", 16'(mdio_o), 16'd0);
      checkOutput("rst mdio_oe", 16'(mdio_oe), 16'd0);
      checkOutput("rst wr_stb", 16'(wr_stb), 16'd0);
      checkOutput("rst wr_addr", 16'(wr_addr), 16'd0);
      checkOutput("rst wr_data", wr_data, 16'h0000);
      checkOutput("rst bmcr", bmcr, 16'h1140);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      readCheck("rd id1", 5'd2, 16'h0141);
      readCheck("rd bmsr down", 5'd1, 16'h7949);
      readCheck("rd anlpar down", 5'd5, 16'h0000);

      writeCheck("wr anar", 5'd4, 16'h0DE1);
      readCheck("rd anar", 5'd4, 16'h0DE1);

      link = 1'b1; speed = 2'b10; duplex = 1'b1;
      readCheck("rd bmsr up", 5'd1, 16'h796D);
      readCheck("rd pssr", 5'd17, 16'hAC00);
      readCheck("rd anlpar up", 5'd5, 16'hC1E1);

      runFrame(31, 2'b10, 5'd1, 5'd2, 16'h0000, 18);
      checkOutput("short preamble no_drive", 16'(oe_seen), 16'd0);
      runFrame(32, 2'b10, 5'd2, 5'd2, 16'h0000, 18);
      checkOutput("wrong phyad no_drive", 16'(oe_seen), 16'd0);
      runFrame(32, 2'b01, 5'd2, 5'd4, 16'h1234, 18);
      checkOutput("wrong phyad no_stb", 16'(stb_cnt), 16'd0);
      readCheck("rd anar kept", 5'd4, 16'h0DE1);

      writeCheck("wr bmcr", 5'd0, 16'h0100);
      checkOutput("bmcr after wr", bmcr, 16'h0100);
      writeCheck("wr bmcr reset", 5'd0, 16'h8000);
      checkOutput("bmcr after soft reset", bmcr, 16'h1140);
      readCheck("rd anar restored", 5'd4, 16'h01E1);
      readCheck("rd bmcr restored", 5'd0, 16'h1140);

      writeCheck("wr unmapped", 5'd9, 16'hBEEF);
      readCheck("rd unmapped", 5'd9, 16'h0000);

      writeCheck("wr bmcr pre-rst", 5'd0, 16'h0100);
      writeCheck("wr anar pre-rst", 5'd4, 16'h0061);
      runFrame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 10);
      checkOutput("mid-read oe", 16'(mdio_oe), 16'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("async rst oe", 16'(mdio_oe), 16'd0);
      checkOutput("async rst bmcr", bmcr, 16'h1140);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      readCheck("rd id2 after rst", 5'd3, 16'h0CC2);
      readCheck("rd anar after rst", 5'd4, 16'h01E1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
